// File: rtl/sifh_peak_reader_pkg.sv
// Shared defaults and FSM state type for the SiFH histogram peak reader.
package sifh_peak_reader_pkg;

  localparam int unsigned NbDefault      = 4;
  localparam int unsigned PeakMaxDefault = 8;
  localparam int unsigned NpDefault      = 1;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StRead  = 2'd1,
    StDrain = 2'd2,
    StDone  = 2'd3
  } state_e;

endpackage

// File: rtl/sifh_peak_cmp.sv
// Running-maximum tracker: keeps the largest value seen and its index; strict compare
// so that ties keep the earliest index.
module sifh_peak_cmp #(
  parameter int unsigned Nb = 4,
  parameter int unsigned PM = 8
) (
  input  logic          clk_i,
  input  logic          res_i,
  input  logic          clr_i,
  input  logic          vld_i,
  input  logic [PM-1:0] data_i,
  input  logic [Nb-1:0] idx_i,
  output logic [PM-1:0] max_nxt_o,
  output logic [Nb-1:0] idx_nxt_o
);

  logic [PM-1:0] max_q, max_d;
  logic [Nb-1:0] idx_q, idx_d;

  always_comb begin
    max_d = max_q;
    idx_d = idx_q;
    if (clr_i) begin
      max_d = '0;
      idx_d = '0;
    end else if (vld_i && (data_i > max_q)) begin
      max_d = data_i;
      idx_d = idx_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (res_i) begin
      max_q <= '0;
      idx_q <= '0;
    end else begin
      max_q <= max_d;
      idx_q <= idx_d;
    end
  end

  // Next-state view lets the caller capture the final result on the last compare edge.
  assign max_nxt_o = max_d;
  assign idx_nxt_o = idx_d;

endmodule

// File: rtl/sifh_peak_reader.sv
// Sweeps a 2^Nb-bin histogram RAM once, reports the peak bin, and optionally clears
// each bin one cycle after its read data returns.
module sifh_peak_reader
  import sifh_peak_reader_pkg::*;
#(
  parameter int unsigned Nb = NbDefault,
  parameter int unsigned PM = PeakMaxDefault
) (
  input  logic          clk,
  input  logic          res,
  input  logic          start,
  input  logic          clrEn,
  input  logic [PM-1:0] counts,
  output logic [Nb-1:0] raddr,
  output logic          rEnable,
  output logic          readFlag,
  output logic [Nb-1:0] waddr,
  output logic          wEnable,
  output logic          writeFlag,
  output logic [PM-1:0] newCounts,
  output logic          busy,
  output logic          done,
  output logic [Nb-1:0] peakAddr,
  output logic [PM-1:0] peakCount
);

  state_e        state_q, state_d;
  logic [Nb-1:0] addr_q, addr_d;
  logic          clr_q, clr_d;
  logic          vld_q;
  logic [Nb-1:0] rd_addr_q;
  logic [Nb-1:0] peak_addr_q, peak_addr_d;
  logic [PM-1:0] peak_cnt_q, peak_cnt_d;
  logic          cmp_clr;
  logic [PM-1:0] cmp_max_nxt;
  logic [Nb-1:0] cmp_idx_nxt;

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    clr_d       = clr_q;
    peak_addr_d = peak_addr_q;
    peak_cnt_d  = peak_cnt_q;
    cmp_clr     = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          clr_d   = clrEn;
          cmp_clr = 1'b1;
          addr_d  = '0;
          state_d = StRead;
        end
      end
      StRead: begin
        if (addr_q == '1) begin
          addr_d  = '0;
          state_d = StDrain;
        end else begin
          addr_d = addr_q + 1'b1;
        end
      end
      StDrain: begin
        // Last word is compared on this edge, so take the compare's next-state.
        peak_addr_d = cmp_idx_nxt;
        peak_cnt_d  = cmp_max_nxt;
        state_d     = StDone;
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (res) begin
      state_q     <= StIdle;
      addr_q      <= '0;
      clr_q       <= 1'b0;
      vld_q       <= 1'b0;
      rd_addr_q   <= '0;
      peak_addr_q <= '0;
      peak_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      clr_q       <= clr_d;
      vld_q       <= (state_q == StRead);
      rd_addr_q   <= addr_q;
      peak_addr_q <= peak_addr_d;
      peak_cnt_q  <= peak_cnt_d;
    end
  end

  sifh_peak_cmp #(
    .Nb (Nb),
    .PM (PM)
  ) u_cmp (
    .clk_i     (clk),
    .res_i     (res),
    .clr_i     (cmp_clr),
    .vld_i     (vld_q),
    .data_i    (counts),
    .idx_i     (rd_addr_q),
    .max_nxt_o (cmp_max_nxt),
    .idx_nxt_o (cmp_idx_nxt)
  );

  assign raddr     = addr_q;
  assign rEnable   = (state_q == StRead);
  assign readFlag  = (state_q == StRead);
  // Clearing trails the read by one cycle: the write hits the bin whose data is returning.
  assign waddr     = rd_addr_q;
  assign wEnable   = vld_q & clr_q;
  assign writeFlag = vld_q & clr_q;
  assign newCounts = '0;
  assign busy      = (state_q != StIdle);
  assign done      = (state_q == StDone);
  assign peakAddr  = peak_addr_q;
  assign peakCount = peak_cnt_q;

endmodule

// File: tb/tb_sifh_peak_reader.sv
// Self-checking bench for sifh_peak_reader with a 16-bin, 1-cycle-latency RAM model.
module tb_sifh_peak_reader;

  localparam int unsigned Nb = 4;
  localparam int unsigned PM = 8;
  localparam int unsigned N  = 16;

  logic          clk = 1'b0;
  logic          res = 1'b1;
  logic          start = 1'b0;
  logic          clrEn = 1'b0;
  logic [PM-1:0] counts = '0;
  logic [Nb-1:0] raddr, waddr, peakAddr;
  logic          rEnable, readFlag, wEnable, writeFlag, busy, done;
  logic [PM-1:0] newCounts, peakCount;

  logic [PM-1:0] mem [N];
  logic [PM-1:0] img [N];
  logic          load = 1'b0;
  bit            rd_seen [N];
  int            wr_cnt = 0;
  int            order_err = 0;

  int errors = 0;
  int checks = 0;

  sifh_peak_reader #(
    .Nb (Nb),
    .PM (PM)
  ) dut (
    .clk       (clk),
    .res       (res),
    .start     (start),
    .clrEn     (clrEn),
    .counts    (counts),
    .raddr     (raddr),
    .rEnable   (rEnable),
    .readFlag  (readFlag),
    .waddr     (waddr),
    .wEnable   (wEnable),
    .writeFlag (writeFlag),
    .newCounts (newCounts),
    .busy      (busy),
    .done      (done),
    .peakAddr  (peakAddr),
    .peakCount (peakCount)
  );

  always #5 clk = ~clk;

  // RAM model (read-first) plus write-ordering monitor.
  always @(posedge clk) begin
    if (load) begin
      mem <= img;
      for (int i = 0; i < N; i++) rd_seen[i] = 1'b0;
    end else if (wEnable && writeFlag) begin
      mem[waddr] <= newCounts;
      wr_cnt = wr_cnt + 1;
      if (!rd_seen[waddr]) order_err = order_err + 1;
    end
    if (rEnable && readFlag) begin
      counts <= mem[raddr];
      rd_seen[raddr] = 1'b1;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, got, exp);
    end
  endtask

  // Reference: first index holding the largest value.
  task automatic ref_peak(output int idx, output int cnt);
    idx = 0;
    cnt = 0;
    for (int i = 0; i < N; i++) begin
      if (int'(img[i]) > cnt) begin
        cnt = int'(img[i]);
        idx = i;
      end
    end
  endtask

  task automatic load_img();
    @(negedge clk);
    load = 1'b1;
    @(negedge clk);
    load = 1'b0;
  endtask

  task automatic rand_img(input int hi);
    for (int i = 0; i < N; i++) img[i] = PM'($urandom_range(hi, 0));
  endtask

  // Starts a sweep and watches a fixed 30-cycle window; lat is the cycle of the first done.
  task automatic sweep(input bit clr, input int rp1, input int rp2,
                       output int lat, output int dones, output int busy_mid);
    @(negedge clk);
    start = 1'b1;
    clrEn = clr;
    lat = -1;
    dones = 0;
    busy_mid = 0;
    for (int n = 1; n <= 30; n++) begin
      @(negedge clk);
      if (done) begin
        dones++;
        if (lat < 0) lat = n;
      end
      if (n == 5) busy_mid = int'(busy);
      start = (n == rp1 || n == rp2);
    end
    start = 1'b0;
  endtask

  task automatic run_and_check(input string tag, input bit clr);
    int lat, dones, bm, ei, ec, w0;
    ref_peak(ei, ec);
    load_img();
    w0 = wr_cnt;
    sweep(clr, 0, 0, lat, dones, bm);
    check({tag, "_lat"}, lat, 18);
    check({tag, "_dones"}, dones, 1);
    check({tag, "_addr"}, peakAddr, ei);
    check({tag, "_cnt"}, peakCount, ec);
    check({tag, "_writes"}, wr_cnt - w0, clr ? N : 0);
  endtask

  initial begin
    int lat, dones, bm, ei, ec, w0;

    repeat (3) @(negedge clk);
    res = 1'b0;
    @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_raddr", raddr, 0);
    check("rst_ren", {rEnable, readFlag, wEnable, writeFlag}, 0);
    check("rst_peak", {peakAddr, peakCount}, 0);
    check("rst_newcounts", newCounts, 0);

    // Single non-zero bin, no clearing.
    for (int i = 0; i < N; i++) img[i] = '0;
    img[9] = 8'd37;
    run_and_check("bin9", 1'b0);
    check("bin9_kept", mem[9], 37);

    // Tie between bins 3 and 12.
    rand_img(49);
    img[3]  = 8'd50;
    img[12] = 8'd50;
    run_and_check("tie", 1'b0);

    // Random bins with clearing.
    for (int r = 0; r < 3; r++) begin
      rand_img(255);
      w0 = order_err;
      run_and_check("rclr", 1'b1);
      check("rclr_order", order_err - w0, 0);
      for (int i = 0; i < N; i++) check("rclr_zero", mem[i], 0);
    end

    // Maximum value in the last bin.
    rand_img(20);
    img[15] = 8'hFF;
    run_and_check("last", 1'b0);

    // All-zero histogram.
    for (int i = 0; i < N; i++) img[i] = '0;
    run_and_check("zero", 1'b1);

    // Start re-pulsed mid-sweep.
    rand_img(150);
    img[5] = 8'd200;
    ref_peak(ei, ec);
    load_img();
    sweep(1'b0, 3, 10, lat, dones, bm);
    check("rp_lat", lat, 18);
    check("rp_dones", dones, 1);
    check("rp_busy_mid", bm, 1);
    check("rp_addr", peakAddr, ei);
    check("rp_cnt", peakCount, ec);

    // Reset at sweep cycle 7.
    rand_img(255);
    load_img();
    @(negedge clk);
    start = 1'b1;
    clrEn = 1'b1;
    for (int n = 1; n <= 7; n++) begin
      @(negedge clk);
      start = 1'b0;
    end
    res = 1'b1;
    @(negedge clk);
    res = 1'b0;
    check("mrst_busy", busy, 0);
    check("mrst_done", done, 0);
    check("mrst_addrs", {raddr, waddr}, 0);
    check("mrst_en", {rEnable, readFlag, wEnable, writeFlag}, 0);
    check("mrst_peak", {peakAddr, peakCount}, 0);
    check("mrst_newcounts", newCounts, 0);
    w0 = wr_cnt;
    repeat (3) @(negedge clk);
    check("mrst_quiet", wr_cnt - w0, 0);
    rand_img(255);
    run_and_check("after_rst", 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
